serdes_in_align: RTL and testbench

- Fabric-side receive aligner for the 4:1 DDR source-synchronous sample bus driven by the DA serializer.
- Sits after per-lane 1:4 deserializers, in the divided-clock domain.
- Finds the bit rotation of the frame lane, whose expected pattern is s0..s3 = 1,1,0,0.
- Re-orders every data lane by that rotation and reports lock.

---
 rtl/serdes_pkg.sv | 38 +++
 rtl/serdes_in_rotate.sv | 22 ++
 rtl/serdes_in_align.sv | 212 +++++++++++++++++++++
 tb/tb_serdes_in_align.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the 4:1 receive aligner: slot count, frame pattern,
// aligner states and the serial-window helpers.
package serdes_pkg;

   localparam int SLOTS = 4;
   localparam logic [SLOTS-1:0] FRAME_PATTERN = 4'b0011;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Four consecutive serial positions starting at k of an 8-deep history.
   function automatic logic [SLOTS-1:0] window_at(input logic [2*SLOTS-1:0] hist,
                                                  input logic [1:0] k);
      logic [2*SLOTS-1:0] sh;
      sh = hist >> k;
      return sh[SLOTS-1:0];
   endfunction

   function automatic logic single_match(input logic [SLOTS-1:0] m);
      return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] match_index(input logic [SLOTS-1:0] m);
      logic [1:0] idx;
      case (m)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/serdes_in_rotate.sv
// Per-lane selector: picks four consecutive serial samples from an 8-deep
// history at the given offset and registers them as aligned slots.
module serdes_in_rotate
   import serdes_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [2*SLOTS-1:0] hist,
   input  logic [1:0]         offset,
   output logic [SLOTS-1:0]   slots
);

   // Registered window select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots <= 4'd0;
      end else begin
         slots <= window_at(hist, offset);
      end
   end

endmodule

// File: rtl/serdes_in_align.sv
// Receive aligner: finds the frame-lane rotation, realigns all data lanes and
// reports lock. Optional health counters under SERDES_IN_ALIGN_STATS_EN.
module serdes_in_align
   import serdes_pkg::*;
#(
   parameter int DATA_WIDTH  = 17,
   parameter int LOCK_COUNT  = 16,
   parameter int UNLOCK_ERRS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  resync,
   input  logic [SLOTS-1:0]      frame_in,
   input  logic [DATA_WIDTH-1:0] din_s0,
   input  logic [DATA_WIDTH-1:0] din_s1,
   input  logic [DATA_WIDTH-1:0] din_s2,
   input  logic [DATA_WIDTH-1:0] din_s3,
   output logic [DATA_WIDTH-1:0] data_s0,
   output logic [DATA_WIDTH-1:0] data_s1,
   output logic [DATA_WIDTH-1:0] data_s2,
   output logic [DATA_WIDTH-1:0] data_s3,
   output logic                  data_valid,
   output logic                  locked,
`ifdef SERDES_IN_ALIGN_STATS_EN
   output logic [15:0]           lock_loss_cnt,
   output logic [15:0]           bad_frame_cnt,
`endif
   output logic [1:0]            slip
);

   localparam int VCW = $clog2(LOCK_COUNT + 1);
   localparam int ECW = $clog2(UNLOCK_ERRS + 1);
   localparam logic [VCW-1:0] VMAX = VCW'(LOCK_COUNT);
   localparam logic [ECW-1:0] EMAX = ECW'(UNLOCK_ERRS);

   logic [SLOTS-1:0][DATA_WIDTH-1:0] din_word_s, cur_r, prev_r;
   logic [SLOTS-1:0]   frame_cur_r, frame_prev_r, match_s;
   logic [2*SLOTS-1:0] frame_hist_s;
   logic               cur_match_s;
   state_t             state_r, state_nx_s;
   logic [1:0]         offset_r, offset_nx_s;
   logic [VCW-1:0]     vcnt_r, vcnt_nx_s, vcnt_inc_s;
   logic [ECW-1:0]     ecnt_r, ecnt_nx_s, ecnt_inc_s;
   logic               locked_r, locked_nx_s, valid_r, valid_nx_s;

   assign din_word_s = {din_s3, din_s2, din_s1, din_s0};

   // Stage 1: current and previous word of every lane
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_r        <= '0;
         prev_r       <= '0;
         frame_cur_r  <= 4'd0;
         frame_prev_r <= 4'd0;
      end else begin
         cur_r        <= din_word_s;
         prev_r       <= cur_r;
         frame_cur_r  <= frame_in;
         frame_prev_r <= frame_cur_r;
      end
   end

   assign frame_hist_s = {frame_cur_r, frame_prev_r};

   // Frame pattern search over all four candidate rotations
   always_comb begin
      match_s = 4'd0;
      for (int k = 0; k < SLOTS; k++) begin
         match_s[k] = (window_at(frame_hist_s, 2'(k)) == FRAME_PATTERN);
      end
   end

   assign cur_match_s = match_s[offset_r];
   assign vcnt_inc_s  = (vcnt_r == VMAX) ? vcnt_r : vcnt_r + VCW'(1);
   assign ecnt_inc_s  = (ecnt_r == EMAX) ? ecnt_r : ecnt_r + ECW'(1);

   for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
      logic [2*SLOTS-1:0] hist_s;
      logic [SLOTS-1:0]   slots_s;

      // Serial history of this lane: prev.s0..s3 then cur.s0..s3
      always_comb begin
         hist_s = 8'd0;
         for (int n = 0; n < SLOTS; n++) begin
            hist_s[n]         = prev_r[n][i];
            hist_s[n + SLOTS] = cur_r[n][i];
         end
      end

      serdes_in_rotate u_rotate (
         .clk    (clk),
         .rst    (rst),
         .hist   (hist_s),
         .offset (offset_r),
         .slots  (slots_s)
      );

      assign data_s0[i] = slots_s[0];
      assign data_s1[i] = slots_s[1];
      assign data_s2[i] = slots_s[2];
      assign data_s3[i] = slots_s[3];
   end

   // FSM state, counters and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= SEARCH;
         offset_r <= 2'd0;
         vcnt_r   <= '0;
         ecnt_r   <= '0;
         locked_r <= 1'b0;
         valid_r  <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         offset_r <= offset_nx_s;
         vcnt_r   <= vcnt_nx_s;
         ecnt_r   <= ecnt_nx_s;
         locked_r <= locked_nx_s;
         valid_r  <= valid_nx_s;
      end
   end

   // Next-state logic; resync overrides any match result
   always_comb begin
      state_nx_s  = state_r;
      offset_nx_s = offset_r;
      vcnt_nx_s   = vcnt_r;
      ecnt_nx_s   = ecnt_r;
      if (resync) begin
         state_nx_s = SEARCH;
         vcnt_nx_s  = '0;
         ecnt_nx_s  = '0;
      end else begin
         case (state_r)
            SEARCH: begin
               if (single_match(match_s)) begin
                  offset_nx_s = match_index(match_s);
                  vcnt_nx_s   = VCW'(1);
                  state_nx_s  = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
               end else begin
                  state_nx_s = SEARCH;
               end
            end
            VERIFY: begin
               if (cur_match_s) begin
                  vcnt_nx_s  = vcnt_inc_s;
                  state_nx_s = (vcnt_inc_s >= VMAX) ? LOCKED : VERIFY;
               end else begin
                  state_nx_s = SEARCH;
                  vcnt_nx_s  = '0;
               end
            end
            LOCKED: begin
               if (cur_match_s) begin
                  ecnt_nx_s = '0;
               end else if (ecnt_inc_s >= EMAX) begin
                  state_nx_s = SEARCH;
                  ecnt_nx_s  = '0;
                  vcnt_nx_s  = '0;
               end else begin
                  ecnt_nx_s = ecnt_inc_s;
               end
            end
            default: begin
               state_nx_s = SEARCH;
               vcnt_nx_s  = '0;
               ecnt_nx_s  = '0;
            end
         endcase
      end
   end

   // Output decode; valid tracks the state used for the word being selected
   always_comb begin
      locked_nx_s = (state_nx_s == LOCKED);
      valid_nx_s  = (state_r == LOCKED);
   end

   assign locked     = locked_r;
   assign data_valid = valid_r;
   assign slip       = offset_r;

`ifdef SERDES_IN_ALIGN_STATS_EN
   logic        bad_evt_s, loss_evt_s;
   logic [15:0] lock_loss_cnt_r, bad_frame_cnt_r;

   assign bad_evt_s  = (state_r == LOCKED) && !resync && !cur_match_s;
   assign loss_evt_s = bad_evt_s && (ecnt_inc_s >= EMAX);

   // Saturating health counters, cleared by resync
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_loss_cnt_r <= 16'd0;
         bad_frame_cnt_r <= 16'd0;
      end else if (resync) begin
         lock_loss_cnt_r <= 16'd0;
         bad_frame_cnt_r <= 16'd0;
      end else begin
         if (loss_evt_s && (lock_loss_cnt_r != 16'hFFFF)) begin
            lock_loss_cnt_r <= lock_loss_cnt_r + 16'd1;
         end
         if (bad_evt_s && (bad_frame_cnt_r != 16'hFFFF)) begin
            bad_frame_cnt_r <= bad_frame_cnt_r + 16'd1;
         end
      end
   end

   assign lock_loss_cnt = lock_loss_cnt_r;
   assign bad_frame_cnt = bad_frame_cnt_r;
`endif

endmodule

// File: tb/tb_serdes_in_align.sv
// Self-checking bench for serdes_in_align: directed phases plus random traffic
// against a serial-stream reference model.
module tb_serdes_in_align;

   localparam int DW = 17;
   localparam int LC = 16;
   localparam int UE = 4;
   localparam logic [3:0] CLEAN0 = 4'b0011;
   localparam logic [3:0] ROT2   = 4'b1100;
   localparam logic [3:0] BAD    = 4'b0000;

   logic          clk, rst, resync;
   logic [3:0]    frame_in;
   logic [DW-1:0] din_s0, din_s1, din_s2, din_s3;
   logic [DW-1:0] data_s0, data_s1, data_s2, data_s3;
   logic          data_valid, locked;
   logic [1:0]    slip;
`ifdef SERDES_IN_ALIGN_STATS_EN
   logic [15:0]   lock_loss_cnt, bad_frame_cnt;
`endif

   serdes_in_align #(.DATA_WIDTH(DW), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE)) dut (
      .clk(clk), .rst(rst), .resync(resync), .frame_in(frame_in),
      .din_s0(din_s0), .din_s1(din_s1), .din_s2(din_s2), .din_s3(din_s3),
      .data_s0(data_s0), .data_s1(data_s1), .data_s2(data_s2), .data_s3(data_s3),
      .data_valid(data_valid), .locked(locked),
`ifdef SERDES_IN_ALIGN_STATS_EN
      .lock_loss_cnt(lock_loss_cnt), .bad_frame_cnt(bad_frame_cnt),
`endif
      .slip(slip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: full serial sample streams plus abstract aligner state.
   bit            fq[$];
   logic [DW-1:0] dq[$];
   int            nw, mst, moff, vc, ec, ll, bf;
   logic [DW-1:0] exp_d[4];
   bit            exp_dv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      dq.delete();
      for (int i = 0; i < 8; i++) begin
         fq.push_back(1'b0);
         dq.push_back('0);
      end
      nw = 2; mst = 0; moff = 0; vc = 0; ec = 0; ll = 0; bf = 0;
      for (int i = 0; i < 4; i++) exp_d[i] = '0;
      exp_dv = 1'b0;
   endtask

   // One clock edge of the model, using the inputs the DUT just sampled.
   task automatic edge_model();
      int base;
      int nm;
      int km;
      bit [3:0] mm;
      bit [3:0] pat;
      logic [DW-1:0] w[4];
      pat = CLEAN0;
      base = 4 * (nw - 2);
      nm = 0; km = 0; mm = 4'd0;
      for (int k = 0; k < 4; k++) begin
         bit ok;
         ok = 1'b1;
         for (int j = 0; j < 4; j++) if (fq[base + k + j] != pat[j]) ok = 1'b0;
         mm[k] = ok;
         if (ok) begin nm++; km = k; end
      end
      for (int n = 0; n < 4; n++) exp_d[n] = dq[base + moff + n];
      exp_dv = (mst == 2);
      if (resync) begin
         mst = 0; vc = 0; ec = 0; ll = 0; bf = 0;
      end else if (mst == 0) begin
         if (nm == 1) begin moff = km; vc = 1; mst = (LC == 1) ? 2 : 1; end
      end else if (mst == 1) begin
         if (mm[moff]) begin vc++; if (vc >= LC) mst = 2; end
         else begin mst = 0; vc = 0; end
      end else begin
         if (mm[moff]) ec = 0;
         else begin
            if (bf < 65535) bf++;
            ec++;
            if (ec >= UE) begin
               mst = 0; ec = 0; vc = 0;
               if (ll < 65535) ll++;
            end
         end
      end
      w[0] = din_s0; w[1] = din_s1; w[2] = din_s2; w[3] = din_s3;
      for (int i = 0; i < 4; i++) begin
         fq.push_back(frame_in[i]);
         dq.push_back(w[i]);
      end
      nw++;
   endtask

   task automatic step(input logic [3:0] fr, input logic rs);
      frame_in = fr;
      resync   = rs;
      din_s0 = DW'($urandom); din_s1 = DW'($urandom);
      din_s2 = DW'($urandom); din_s3 = DW'($urandom);
      @(posedge clk);
      edge_model();
      #1;
      check("data_s0", 32'(data_s0), 32'(exp_d[0]));
      check("data_s1", 32'(data_s1), 32'(exp_d[1]));
      check("data_s2", 32'(data_s2), 32'(exp_d[2]));
      check("data_s3", 32'(data_s3), 32'(exp_d[3]));
      check("data_valid", 32'(data_valid), 32'(exp_dv));
      check("locked", 32'(locked), 32'(mst == 2));
      check("slip", 32'(slip), 32'(moff));
`ifdef SERDES_IN_ALIGN_STATS_EN
      check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(ll));
      check("bad_frame_cnt", 32'(bad_frame_cnt), 32'(bf));
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_d0"}, 32'(data_s0), 32'd0);
      check({tag, "_d1"}, 32'(data_s1), 32'd0);
      check({tag, "_d2"}, 32'(data_s2), 32'd0);
      check({tag, "_d3"}, 32'(data_s3), 32'd0);
      check({tag, "_valid"}, 32'(data_valid), 32'd0);
      check({tag, "_locked"}, 32'(locked), 32'd0);
      check({tag, "_slip"}, 32'(slip), 32'd0);
`ifdef SERDES_IN_ALIGN_STATS_EN
      check({tag, "_loss"}, 32'(lock_loss_cnt), 32'd0);
      check({tag, "_bad"}, 32'(bad_frame_cnt), 32'd0);
`endif
   endtask

   task automatic wait_lock(output int steps, input logic [3:0] fr);
      steps = 0;
      while (!locked && steps < 60) begin
         step(fr, 1'b0);
         steps++;
      end
      check("lock_within_bound", 32'(locked), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int steps;
      logic [3:0] seq_c[10];
      logic [3:0] rots[4];
      logic [3:0] fr;
      logic       rs;

      rst = 1'b1; resync = 1'b0; frame_in = 4'd0;
      din_s0 = '0; din_s1 = '0; din_s2 = '0; din_s3 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_zero("reset");
      @(negedge clk) rst = 1'b0;

      // Clean frame at rotation 0: two fill words, then 16 verified frames
      wait_lock(steps, CLEAN0);
      check("lock_steps_clean", 32'(steps), 32'd18);
      check("slip_clean", 32'(slip), 32'd0);
      repeat (8) step(CLEAN0, 1'b0);

      // 3 bad, 1 good, 3 bad never reaches the unlock threshold
      seq_c = '{BAD, BAD, BAD, CLEAN0, BAD, BAD, BAD, CLEAN0, CLEAN0, CLEAN0};
      for (int i = 0; i < 10; i++) begin
         step(seq_c[i], 1'b0);
         check("lock_hold", 32'(locked), 32'd1);
      end

      // 4 consecutive bad frames; evaluation trails input by two words
      repeat (4) step(BAD, 1'b0);
      step(CLEAN0, 1'b0);
      check("lock_before_4th", 32'(locked), 32'd1);
      step(CLEAN0, 1'b0);
      check("lock_after_4th", 32'(locked), 32'd0);
`ifdef SERDES_IN_ALIGN_STATS_EN
      check("loss_after_4th", 32'(lock_loss_cnt), 32'd1);
`endif
      wait_lock(steps, CLEAN0);

      // Resync while locked on a clean frame
      step(CLEAN0, 1'b1);
      check("resync_drop", 32'(locked), 32'd0);
      wait_lock(steps, CLEAN0);
      check("resync_relock_steps", 32'(steps), 32'd16);

      // Frame rotated by two slots
      step(ROT2, 1'b1);
      wait_lock(steps, ROT2);
      check("slip_rot2", 32'(slip), 32'd2);
      repeat (6) step(ROT2, 1'b0);

      // Reset in the middle of VERIFY
      step(ROT2, 1'b1);
      steps = 0;
      while (vc != 10 && steps < 40) begin
         step(ROT2, 1'b0);
         steps++;
      end
      check("pre_rst_locked", 32'(locked), 32'd0);
      rst = 1'b1;
      #1 check_zero("mid_reset");
      model_reset();
      @(negedge clk) rst = 1'b0;
      wait_lock(steps, ROT2);
      check("rst_relock_steps", 32'(steps), 32'd18);
      check("slip_after_rst", 32'(slip), 32'd2);

      // Random traffic: random rotation, sporadic corrupt frames and resyncs
      rots = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
      fr = CLEAN0;
      for (int i = 0; i < 400; i++) begin
         rs = 1'b0;
         if (i % 80 == 0) begin
            fr = rots[$urandom_range(0, 3)];
            rs = 1'b1;
         end else if ($urandom_range(0, 99) == 0) begin
            rs = 1'b1;
         end
         if ($urandom_range(0, 9) == 0) step(4'($urandom), rs);
         else step(fr, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
